// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix scan driver: FSM state encoding and
// default parameter constants used by the top level and the BCM timer.
package matrix_pkg;

    localparam int DEF_MATRIX_WIDTH    = 64;
    localparam int DEF_DATA_WIDTH      = 8;
    localparam int DEF_SCAN_VAL_LENGTH = 5;
    localparam int DEF_SCAN_ROWS       = 16;
    localparam int DEF_BASE_TICKS      = 8;

    // One pass per row/bit-plane: FETCH -> CAPTURE -> SHIFT -> LATCH -> DISPLAY.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_LATCH   = 3'd4,
        ST_DISPLAY = 3'd5
    } scan_state_t;

    // Counter width able to hold the longest display period (inclusive).
    function automatic int ticks_width(input int base_ticks, input int data_width);
        return $clog2((base_ticks << (data_width - 1)) + 1);
    endfunction

endpackage

// File: rtl/matrix_bcm_timer.sv
// Bit-plane display timer: loads a duration, counts it down while running and
// flags the final cycle. With MATRIX_SCAN_BRIGHTNESS_EN defined it also
// produces an output-enable gate that is true only for the leading
// (duration * (brightness + 1)) >> 8 cycles of the period; the period itself
// is unchanged. Without the macro the gate is always true.
module matrix_bcm_timer
    import matrix_pkg::*;
#(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] duration,
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    input  logic [7:0]       brightness,
`endif
    output logic             done,
    output logic             oe_gate
);

    logic [CNT_W-1:0] cnt;

    // Remaining cycles of the current display period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= duration;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // The cycle holding a count of one is the last cycle of the period.
    assign done = run && (cnt <= CNT_W'(1));

`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    logic [CNT_W+8:0] prod;
    logic [CNT_W-1:0] on_len;
    logic [CNT_W-1:0] on_cnt;

    // Scaled lit length; brightness 255 gives the full period.
    always_comb begin
        prod   = {9'd0, duration} * {{CNT_W{1'b0}}, ({1'b0, brightness} + 9'd1)};
        on_len = CNT_W'(prod >> 8);
    end

    // Remaining lit cycles; the gate closes once this reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_cnt <= '0;
        end else if (load) begin
            on_cnt <= on_len;
        end else if (run && (on_cnt != '0)) begin
            on_cnt <= on_cnt - 1'b1;
        end
    end

    assign oe_gate = (on_cnt != '0);
`else
    assign oe_gate = 1'b1;
`endif

endmodule

// File: rtl/matrix_scan_driver.sv
// HUB75-style LED matrix scan driver with binary code modulation.
// For each row pair and bit plane: request data from matrix_memory, capture
// six column vectors, shift them out MSB column first on panel_clk, latch,
// then light the row for BASE_TICKS << bit cycles.
// Optional feature: define MATRIX_SCAN_BRIGHTNESS_EN to add an 8-bit
// brightness input that shortens the lit part of each display period.
//
// Handshake with matrix_memory: scan_val/current_bcm_bit are stable in FETCH;
// pwm_data_* are taken one cycle later, in CAPTURE. There is no ready/valid
// pair; the fixed one-cycle latency is the whole contract.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int MATRIX_WIDTH    = DEF_MATRIX_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int SCAN_VAL_LENGTH = DEF_SCAN_VAL_LENGTH,
    parameter int SCAN_ROWS       = DEF_SCAN_ROWS,
    parameter int BASE_TICKS      = DEF_BASE_TICKS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    input  logic [7:0]                 brightness,
`endif
    output logic [SCAN_VAL_LENGTH-1:0] scan_val,
    output logic [DATA_WIDTH-1:0]      current_bcm_bit,
    input  logic [MATRIX_WIDTH-1:0]    pwm_data_ra,
    input  logic [MATRIX_WIDTH-1:0]    pwm_data_ga,
    input  logic [MATRIX_WIDTH-1:0]    pwm_data_ba,
    input  logic [MATRIX_WIDTH-1:0]    pwm_data_rb,
    input  logic [MATRIX_WIDTH-1:0]    pwm_data_gb,
    input  logic [MATRIX_WIDTH-1:0]    pwm_data_bb,
    output logic                       r1,
    output logic                       g1,
    output logic                       b1,
    output logic                       r2,
    output logic                       g2,
    output logic                       b2,
    output logic                       panel_clk,
    output logic                       lat,
    output logic                       oe_n,
    output logic [SCAN_VAL_LENGTH-1:0] addr,
    output logic                       frame_start
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int SH_W  = $clog2(2 * MATRIX_WIDTH);
    localparam int CNT_W = ticks_width(BASE_TICKS, DATA_WIDTH);

    scan_state_t state, state_nxt;

    logic [SCAN_VAL_LENGTH-1:0] row_q;
    logic [BIT_W-1:0]           bit_q;
    logic [SH_W-1:0]            sh_cnt;
    logic [MATRIX_WIDTH-1:0]    sr_r1, sr_g1, sr_b1, sr_r2, sr_g2, sr_b2;
    logic                       last_shift;
    logic                       tmr_done;
    logic                       oe_gate;
    logic [CNT_W-1:0]           duration;

    assign last_shift = (sh_cnt == SH_W'(2 * MATRIX_WIDTH - 1));
    assign duration   = CNT_W'(BASE_TICKS) << bit_q;
    assign scan_val   = row_q;
    assign current_bcm_bit = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << bit_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and panel-side outputs; everything idles low except oe_n.
    always_comb begin
        state_nxt   = state;
        panel_clk   = 1'b0;
        lat         = 1'b0;
        oe_n        = 1'b1;
        frame_start = 1'b0;
        r1 = 1'b0; g1 = 1'b0; b1 = 1'b0;
        r2 = 1'b0; g2 = 1'b0; b2 = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                frame_start = (row_q == '0) && (bit_q == '0);
                state_nxt   = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Data moves while panel_clk is low, held while it is high.
                panel_clk = sh_cnt[0];
                r1 = sr_r1[MATRIX_WIDTH-1];
                g1 = sr_g1[MATRIX_WIDTH-1];
                b1 = sr_b1[MATRIX_WIDTH-1];
                r2 = sr_r2[MATRIX_WIDTH-1];
                g2 = sr_g2[MATRIX_WIDTH-1];
                b2 = sr_b2[MATRIX_WIDTH-1];
                if (last_shift) state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                lat       = 1'b1;
                state_nxt = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                oe_n = ~oe_gate;
                // enable is only sampled here, so a row/bit always finishes.
                if (tmr_done) state_nxt = enable ? ST_FETCH : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Half-bit counter for the shift phase; even = clock low, odd = clock high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_cnt <= '0;
        end else if (state == ST_CAPTURE) begin
            sh_cnt <= '0;
        end else if (state == ST_SHIFT) begin
            sh_cnt <= sh_cnt + 1'b1;
        end
    end

    // Column shift registers: load in CAPTURE, advance after each high phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r1 <= '0; sr_g1 <= '0; sr_b1 <= '0;
            sr_r2 <= '0; sr_g2 <= '0; sr_b2 <= '0;
        end else if (state == ST_CAPTURE) begin
            sr_r1 <= pwm_data_ra; sr_g1 <= pwm_data_ga; sr_b1 <= pwm_data_ba;
            sr_r2 <= pwm_data_rb; sr_g2 <= pwm_data_gb; sr_b2 <= pwm_data_bb;
        end else if ((state == ST_SHIFT) && sh_cnt[0]) begin
            sr_r1 <= {sr_r1[MATRIX_WIDTH-2:0], 1'b0};
            sr_g1 <= {sr_g1[MATRIX_WIDTH-2:0], 1'b0};
            sr_b1 <= {sr_b1[MATRIX_WIDTH-2:0], 1'b0};
            sr_r2 <= {sr_r2[MATRIX_WIDTH-2:0], 1'b0};
            sr_g2 <= {sr_g2[MATRIX_WIDTH-2:0], 1'b0};
            sr_b2 <= {sr_b2[MATRIX_WIDTH-2:0], 1'b0};
        end
    end

    // Row/bit-plane position: bits advance first, rows advance on bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            bit_q <= '0;
        end else if ((state == ST_DISPLAY) && tmr_done) begin
            if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                bit_q <= '0;
                row_q <= (row_q == SCAN_VAL_LENGTH'(SCAN_ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
                bit_q <= bit_q + 1'b1;
            end
        end
    end

    // Panel row address follows the row just shifted in, updated at the latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (state == ST_LATCH) begin
            addr <= row_q;
        end
    end

`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    logic [7:0] brt_q;

    // Brightness is frozen for a whole frame to avoid mid-frame steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brt_q <= '0;
        end else if (frame_start) begin
            brt_q <= brightness;
        end
    end
`endif

    matrix_bcm_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (state == ST_LATCH),
        .run        (state == ST_DISPLAY),
        .duration   (duration),
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
        .brightness (brt_q),
`endif
        .done       (tmr_done),
        .oe_gate    (oe_gate)
    );

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Bench for matrix_scan_driver: a behavioural matrix_memory with random
// contents feeds the DUT; every row/bit pass is decoded from the panel pins
// and compared with a row/bit sequence model computed from the scan rules.
module tb_matrix_scan_driver;

    localparam int W    = 64;
    localparam int DW   = 8;
    localparam int SVL  = 5;
    localparam int ROWS = 16;
    localparam int BASE = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    logic [SVL-1:0] scan_val, addr;
    logic [DW-1:0]  current_bcm_bit;
    logic [W-1:0]   pwm_data_ra, pwm_data_ga, pwm_data_ba;
    logic [W-1:0]   pwm_data_rb, pwm_data_gb, pwm_data_bb;
    logic r1, g1, b1, r2, g2, b2, panel_clk, lat, oe_n, frame_start;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    logic [7:0] brightness = 8'd255;
`endif
    int brt = 255;

    int n_vec = 0;
    int n_err = 0;
    int fs_count = 0;
    int fs_bad = 0;
    int exp_row = 0;
    int exp_bit = 0;

    logic [W-1:0] mem_ra[ROWS][DW];
    logic [W-1:0] mem_ga[ROWS][DW];
    logic [W-1:0] mem_ba[ROWS][DW];
    logic [W-1:0] mem_rb[ROWS][DW];
    logic [W-1:0] mem_gb[ROWS][DW];
    logic [W-1:0] mem_bb[ROWS][DW];

    matrix_scan_driver #(
        .MATRIX_WIDTH(W), .DATA_WIDTH(DW), .SCAN_VAL_LENGTH(SVL),
        .SCAN_ROWS(ROWS), .BASE_TICKS(BASE)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .scan_val(scan_val), .current_bcm_bit(current_bcm_bit),
        .pwm_data_ra(pwm_data_ra), .pwm_data_ga(pwm_data_ga), .pwm_data_ba(pwm_data_ba),
        .pwm_data_rb(pwm_data_rb), .pwm_data_gb(pwm_data_gb), .pwm_data_bb(pwm_data_bb),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .panel_clk(panel_clk), .lat(lat), .oe_n(oe_n), .addr(addr),
        .frame_start(frame_start)
    );

    function automatic int oh2idx(input logic [DW-1:0] v);
        for (int i = 0; i < DW; i++) if (v[i]) return i;
        return 0;
    endfunction

    // matrix_memory model: one-cycle read latency.
    always @(posedge clk) begin
        pwm_data_ra <= mem_ra[scan_val[3:0]][oh2idx(current_bcm_bit)];
        pwm_data_ga <= mem_ga[scan_val[3:0]][oh2idx(current_bcm_bit)];
        pwm_data_ba <= mem_ba[scan_val[3:0]][oh2idx(current_bcm_bit)];
        pwm_data_rb <= mem_rb[scan_val[3:0]][oh2idx(current_bcm_bit)];
        pwm_data_gb <= mem_gb[scan_val[3:0]][oh2idx(current_bcm_bit)];
        pwm_data_bb <= mem_bb[scan_val[3:0]][oh2idx(current_bcm_bit)];
    end

    // frame_start pulse counter; a pulse anywhere but row 0 / bit 0 is logged.
    always @(negedge clk) begin
        if (!rst && frame_start) begin
            fs_count++;
            if (scan_val != 0 || current_bcm_bit != 1) fs_bad++;
        end
    end

    // ---------------- reference model ----------------
    function automatic int exp_on_cycles(input int b);
        int d;
        d = BASE * (2 ** b);
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
        return (d * (brt + 1)) / 256;
`else
        return d;
`endif
    endfunction

    task automatic model_advance();
        exp_bit++;
        if (exp_bit == DW) begin
            exp_bit = 0;
            exp_row = (exp_row + 1) % ROWS;
        end
    endtask

    // ---------------- driver / observer ----------------
    // Observe one complete row/bit pass starting anywhere before its shift
    // phase; returns at the first sample after the lit window.
    task automatic observe_rowbit(input bit drop_mid);
        logic [W-1:0] c_ra, c_ga, c_ba, c_rb, c_gb, c_bb;
        logic [DW-1:0] exp_oh;
        logic prev;
        int rises, cyc, hi, lo, latbad;
        rises = 0; cyc = 0; hi = 0; prev = 1'b0;
        c_ra = '0; c_ga = '0; c_ba = '0; c_rb = '0; c_gb = '0; c_bb = '0;
        while (rises < W && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (panel_clk) hi++;
            if (panel_clk && !prev) begin
                c_ra = {c_ra[W-2:0], r1}; c_ga = {c_ga[W-2:0], g1}; c_ba = {c_ba[W-2:0], b1};
                c_rb = {c_rb[W-2:0], r2}; c_gb = {c_gb[W-2:0], g2}; c_bb = {c_bb[W-2:0], b2};
                rises++;
                if (drop_mid && rises == W / 2) enable = 1'b0;
            end
            prev = panel_clk;
        end
        n_vec++;
        if (rises != W) begin
            n_err++;
            $display("FAIL shift_timeout row %0d bit %0d: got %0d rises required %0d", exp_row, exp_bit, rises, W);
            model_advance();
            return;
        end
        n_vec++;
        if (hi !== W) begin
            n_err++;
            $display("FAIL panel_clk_high_cycles: got %0d required %0d", hi, W);
        end
        n_vec++;
        if ({c_ra, c_ga, c_ba, c_rb, c_gb, c_bb} !==
            {mem_ra[exp_row][exp_bit], mem_ga[exp_row][exp_bit], mem_ba[exp_row][exp_bit],
             mem_rb[exp_row][exp_bit], mem_gb[exp_row][exp_bit], mem_bb[exp_row][exp_bit]}) begin
            n_err++;
            $display("FAIL shift_data row %0d bit %0d: got r1 %h required %h", exp_row, exp_bit,
                     c_ra, mem_ra[exp_row][exp_bit]);
        end
        // LATCH cycle
        @(negedge clk);
        exp_oh = DW'(1 << exp_bit);
        n_vec++;
        if ({lat, oe_n, panel_clk, r1, g1, b1, r2, g2, b2} !== 9'b110000000) begin
            n_err++;
            $display("FAIL latch_cycle: got lat/oe_n/clk/data %b required 110000000",
                     {lat, oe_n, panel_clk, r1, g1, b1, r2, g2, b2});
        end
        n_vec++;
        if (scan_val !== SVL'(exp_row) || current_bcm_bit !== exp_oh) begin
            n_err++;
            $display("FAIL row_bit_request: got row %0d bits %b required row %0d bits %b",
                     scan_val, current_bcm_bit, exp_row, exp_oh);
        end
        // DISPLAY
        @(negedge clk);
        n_vec++;
        if (addr !== SVL'(exp_row)) begin
            n_err++;
            $display("FAIL addr: got %0d required %0d", addr, exp_row);
        end
        lo = 0; latbad = 0;
        while (oe_n === 1'b0 && lo < 3000) begin
            lo++;
            if (lat !== 1'b0) latbad++;
            @(negedge clk);
        end
        n_vec++;
        if (lo !== exp_on_cycles(exp_bit) || latbad != 0) begin
            n_err++;
            $display("FAIL display_len row %0d bit %0d: got %0d (lat errs %0d) required %0d",
                     exp_row, exp_bit, lo, latbad, exp_on_cycles(exp_bit));
        end
        model_advance();
    endtask

    task automatic do_reset();
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_row = 0;
        exp_bit = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({oe_n, lat, panel_clk, frame_start, r1, g1, b1, r2, g2, b2} !== 10'b1000000000 ||
            scan_val !== 0 || addr !== 0 || current_bcm_bit !== 8'd1) begin
            n_err++;
            $display("FAIL reset_values: got oe_n %b lat %b clk %b scan %0d addr %0d bits %b",
                     oe_n, lat, panel_clk, scan_val, addr, current_bcm_bit);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++;
        if (oe_n !== 1'b1 || panel_clk !== 1'b0) begin
            n_err++;
            $display("FAIL idle_without_enable: got oe_n %b clk %b required 1 0", oe_n, panel_clk);
        end
    endtask

    task automatic test_frame();
        int fs0;
        fs0 = fs_count;
        enable = 1'b1;
        for (int i = 0; i < ROWS * DW; i++) observe_rowbit(1'b0);
        n_vec++;
        if (fs_count - fs0 != 1) begin
            n_err++;
            $display("FAIL frame_start_once: got %0d pulses required 1", fs_count - fs0);
        end
        observe_rowbit(1'b0);
        n_vec++;
        if (fs_count - fs0 != 2 || fs_bad != 0) begin
            n_err++;
            $display("FAIL frame_start_wrap: got %0d pulses (%0d misplaced) required 2 (0)",
                     fs_count - fs0, fs_bad);
        end
    endtask

    task automatic test_reset_mid_display();
        int cyc;
        for (int i = 1; i < DW; i++) observe_rowbit(1'b0);
        cyc = 0;
        while (lat !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (oe_n !== 1'b0 || addr !== 5'd1) begin
            n_err++;
            $display("FAIL pre_reset_display: got oe_n %b addr %0d required 0 1", oe_n, addr);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (oe_n !== 1'b1 || addr !== 0 || lat !== 1'b0 || scan_val !== 0 ||
            current_bcm_bit !== 8'd1 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_display: got oe_n %b addr %0d lat %b scan %0d bits %b",
                     oe_n, addr, lat, scan_val, current_bcm_bit);
        end
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_row = 0;
        exp_bit = 0;
    endtask

    task automatic test_enable_drop();
        int bad;
        enable = 1'b1;
        observe_rowbit(1'b1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (oe_n !== 1'b1 || panel_clk !== 1'b0 || lat !== 1'b0) bad++;
            @(negedge clk);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL idle_after_drop: got %0d active cycles required 0", bad);
        end
        n_vec++;
        if (scan_val !== 0 || current_bcm_bit !== 8'd2) begin
            n_err++;
            $display("FAIL held_next_rowbit: got row %0d bits %b required 0 00000010",
                     scan_val, current_bcm_bit);
        end
        enable = 1'b1;
        observe_rowbit(1'b0);
    endtask

    task automatic test_reset_mid_shift();
        int rises, cyc;
        logic prev;
        rises = 0; cyc = 0; prev = 1'b0;
        while (rises < 10 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (panel_clk && !prev) rises++;
            prev = panel_clk;
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({panel_clk, r1, g1, b1, r2, g2, b2, lat, oe_n} !== 9'b000000001 ||
            scan_val !== 0 || current_bcm_bit !== 8'd1 || rises != 10) begin
            n_err++;
            $display("FAIL async_reset_shift: got clk/data/lat/oe_n %b scan %0d rises %0d",
                     {panel_clk, r1, g1, b1, r2, g2, b2, lat, oe_n}, scan_val, rises);
        end
        do_reset();
    endtask

`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    task automatic test_brightness();
        int k, bad;
        brightness = 8'd127;
        brt = 127;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) observe_rowbit(1'b0);
        k = 0; bad = 0;
        while (panel_clk !== 1'b1 && k < 3000) begin
            if (oe_n !== 1'b1) bad++;
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k != 35 || bad != 0) begin
            n_err++;
            $display("FAIL brightness_dark_tail: got %0d cycles (%0d lit) required 35 (0)", k, bad);
        end
        do_reset();
    endtask
`endif

    initial begin
        for (int r = 0; r < ROWS; r++) begin
            for (int b = 0; b < DW; b++) begin
                mem_ra[r][b] = {$urandom, $urandom};
                mem_ga[r][b] = {$urandom, $urandom};
                mem_ba[r][b] = {$urandom, $urandom};
                mem_rb[r][b] = {$urandom, $urandom};
                mem_gb[r][b] = {$urandom, $urandom};
                mem_bb[r][b] = {$urandom, $urandom};
            end
        end
        mem_ra[5][0] = 64'h8000_0000_0000_0001;

        test_reset();
        test_frame();
        test_reset_mid_display();
        test_enable_drop();
        test_reset_mid_shift();
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
